// File: rtl/carry_look_ahead_adder.sv
// rtl/carry_look_ahead_adder.sv - registered two-level carry-lookahead adder
// 4-bit lookahead groups feed a recursive lookahead tree of 4-wide blocks; the sum is registered.

module cla_lcu #(
   parameter int W = 4
) (
   input  logic [W-1:0] g,
   input  logic [W-1:0] p,
   input  logic         cin,
   output logic [W-1:0] c,
   output logic         gg,
   output logic         pg
);

   // Group generate/propagate never depend on cin, so they live apart from the carries.
   always_comb begin
      logic t;
      t  = 1'b0;
      gg = 1'b0;
      pg = 1'b1;
      for (int j = 0; j < W; j++) begin
         t = g[j];
         for (int k = j + 1; k < W; k++) t = t & p[k];
         gg = gg | t;
         pg = pg & p[j];
      end
   end

   // Each carry is a flat sum of products over g/p/cin, no ripple between positions.
   always_comb begin
      logic t;
      t = 1'b0;
      c = '0;
      for (int i = 0; i < W; i++) begin
         t = cin;
         for (int k = 0; k < i; k++) t = t & p[k];
         c[i] = t;
         for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int k = j + 1; k < i; k++) t = t & p[k];
            c[i] = c[i] | t;
         end
      end
   end

endmodule

module cla_lookahead #(
   parameter int N = 4
) (
   input  logic [N-1:0] g,
   input  logic [N-1:0] p,
   input  logic         cin,
   output logic [N-1:0] c,
   output logic         gg,
   output logic         pg
);

   if (N <= 4) begin : g_leaf
      cla_lcu #(.W(N)) u_lcu (
         .g   (g),
         .p   (p),
         .cin (cin),
         .c   (c),
         .gg  (gg),
         .pg  (pg)
      );
   end else begin : g_tier
      localparam int NB = (N + 3) / 4;

      logic [NB-1:0] bg;
      logic [NB-1:0] bp;
      logic [NB-1:0] bc;

      for (genvar b = 0; b < NB; b++) begin : g_blk
         localparam int LO = 4 * b;
         localparam int BW = (N - LO > 4) ? 4 : (N - LO);
         cla_lcu #(.W(BW)) u_lcu (
            .g   (g[LO+BW-1:LO]),
            .p   (p[LO+BW-1:LO]),
            .cin (bc[b]),
            .c   (c[LO+BW-1:LO]),
            .gg  (bg[b]),
            .pg  (bp[b])
         );
      end

      // Next tier up resolves the block carry-ins from the block (G,P) pairs.
      cla_lookahead #(.N(NB)) u_up (
         .g   (bg),
         .p   (bp),
         .cin (cin),
         .c   (bc),
         .gg  (gg),
         .pg  (pg)
      );
   end

endmodule

module carry_look_ahead_adder #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [BITS-1:0] summand1_32_bits,
   input  logic [BITS-1:0] summand2_32_bits,
   output logic [BITS:0]   outputSum
);

   localparam int NG = BITS / 4;

   logic [BITS-1:0] g;
   logic [BITS-1:0] p;
   logic [BITS-1:0] c;
   logic [BITS-1:0] sum;
   logic [NG-1:0]   grp_g;
   logic [NG-1:0]   grp_p;
   logic [NG-1:0]   grp_c;
   logic            carry_in;
   logic            top_g;
   logic            top_p;
   logic            carry_out;

   assign carry_in = 1'b0;
   assign g        = summand1_32_bits & summand2_32_bits;
   assign p        = summand1_32_bits ^ summand2_32_bits;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_lcu #(.W(4)) u_grp (
         .g   (g[4*k+3:4*k]),
         .p   (p[4*k+3:4*k]),
         .cin (grp_c[k]),
         .c   (c[4*k+3:4*k]),
         .gg  (grp_g[k]),
         .pg  (grp_p[k])
      );
   end

   cla_lookahead #(.N(NG)) u_lvl2 (
      .g   (grp_g),
      .p   (grp_p),
      .cin (carry_in),
      .c   (grp_c),
      .gg  (top_g),
      .pg  (top_p)
   );

   assign carry_out = top_g | (top_p & carry_in);
   assign sum       = p ^ c;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) outputSum <= '0;
      else      outputSum <= {carry_out, sum};
   end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// tb/tb_carry_look_ahead_adder.sv - vector, reset and random checks of the registered CLA adder
// Three widths (32/16/8) share clock and reset; expectations come from plain integer addition.

module tb_carry_look_ahead_adder;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [32:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] a32, b32;
   logic [15:0] a16, b16;
   logic [7:0]  a8, b8;
   logic [32:0] s32;
   logic [16:0] s16;
   logic [8:0]  s8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   carry_look_ahead_adder #(.BITS(32)) dut32 (
      .clk(clk), .clr(clr), .summand1_32_bits(a32), .summand2_32_bits(b32), .outputSum(s32));
   carry_look_ahead_adder #(.BITS(16)) dut16 (
      .clk(clk), .clr(clr), .summand1_32_bits(a16), .summand2_32_bits(b16), .outputSum(s16));
   carry_look_ahead_adder #(.BITS(8)) dut8 (
      .clk(clk), .clr(clr), .summand1_32_bits(a8), .summand2_32_bits(b8), .outputSum(s8));

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b);
      a32 = a;       b32 = b;
      a16 = a[15:0]; b16 = b[15:0];
      a8  = a[7:0];  b8  = b[7:0];
   endtask

   vec_t        vt[8];
   logic [32:0] prev;
   logic [32:0] e32;
   logic [16:0] e16;
   logic [8:0]  e8;
   logic [31:0] ra, rb;

   initial begin
      vt[0] = '{"add_2_2",     32'h0000_0002, 32'h0000_0002, 33'h0_0000_0004};
      vt[1] = '{"add_5_6",     32'h0000_0005, 32'h0000_0006, 33'h0_0000_000B};
      vt[2] = '{"add_7_7",     32'h0000_0007, 32'h0000_0007, 33'h0_0000_000E};
      vt[3] = '{"carry_all",   32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
      vt[4] = '{"carry_16",    32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000};
      vt[5] = '{"max_ops",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
      vt[6] = '{"alternating", 32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF};
      vt[7] = '{"zeros",       32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};

      drive(32'h5, 32'h6);
      #2 clr = 1'b0;
      #1;
      check("reset_async", s32, 33'h0);
      for (int i = 0; i < 3; i++) begin
         step;
         check("reset_hold32", s32, 33'h0);
         check("reset_hold16", {16'h0, s16}, 33'h0);
         check("reset_hold8", {24'h0, s8}, 33'h0);
      end

      drive(32'h0, 32'h1);
      clr = 1'b1;
      step;
      check("release32", s32, 33'h1);
      check("release16", {16'h0, s16}, 33'h1);
      check("release8", {24'h0, s8}, 33'h1);
      prev = 33'h1;

      for (int i = 0; i < 8; i++) begin
         drive(vt[i].a, vt[i].b);
         #3;
         check({vt[i].name, "_hold"}, s32, prev);
         step;
         check(vt[i].name, s32, vt[i].exp);
         prev = vt[i].exp;
      end

      a8 = 8'hFF;    b8 = 8'h01;
      a16 = 16'hFFFF; b16 = 16'hFFFF;
      step;
      check("w8_carry", {24'h0, s8}, 33'h100);
      check("w16_max", {16'h0, s16}, 33'h1FFFE);
      a8 = 8'hFF; b8 = 8'hFF;
      step;
      check("w8_max", {24'h0, s8}, 33'h1FE);

      drive(32'h8000_0000, 32'h8000_0000);
      step;
      check("msb_carry", s32, 33'h1_0000_0000);
      #2 clr = 1'b0;
      #1;
      check("midstream_async", s32, 33'h0);
      step;
      check("midstream_hold", s32, 33'h0);
      clr = 1'b1;
      drive(32'h3, 32'h4);
      step;
      check("midstream_release32", s32, 33'h7);
      check("midstream_release8", {24'h0, s8}, 33'h7);

      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 16 == 0) rb = ~ra;
         drive(ra, rb);
         e32 = {1'b0, ra} + {1'b0, rb};
         e16 = {1'b0, ra[15:0]} + {1'b0, rb[15:0]};
         e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]};
         step;
         check("rand32", s32, e32);
         check("rand16", {16'h0, s16}, {16'h0, e16});
         check("rand8", {24'h0, s8}, {24'h0, e8});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
